// File: rtl/sysa_pkg.sv
// Shared constants for the weight-stationary systolic multiply array.
// Geometry, datapath widths and pipeline latency live here.
package sysa_pkg;

  localparam int N       = 3;
  localparam int DW      = 8;
  localparam int OW      = 16;
  localparam int LATENCY = 2 * N - 2;
  localparam int WSTRIDE = 32;

endpackage

// File: rtl/sysa_pe.sv
// One processing element: stationary weight, forwarded activation,
// and a multiply-accumulate partial sum passed to the row below.
module sysa_pe
  import sysa_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] w_in,
  input  logic [DW-1:0] a_in,
  input  logic [OW-1:0] psum_in,
  output logic [DW-1:0] a_out,
  output logic [OW-1:0] psum_out
);

  logic [DW-1:0]   w_q, w_d;
  logic [DW-1:0]   a_q, a_d;
  logic [OW-1:0]   psum_q, psum_d;
  logic [2*DW-1:0] prod;

  always_comb begin
    w_d    = w_q;
    a_d    = a_q;
    psum_d = psum_q;
    prod   = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, w_q};
    // Weights only load while the pipeline is stalled.
    if (!en) begin
      w_d = w_in;
    end else begin
      a_d    = a_in;
      psum_d = psum_in + OW'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q    <= '0;
      a_q    <= '0;
      psum_q <= '0;
    end else begin
      w_q    <= w_d;
      a_q    <= a_d;
      psum_q <= psum_d;
    end
  end

  assign a_out    = a_q;
  assign psum_out = psum_q;

endmodule

// File: rtl/sysa_array.sv
// N x N weight-stationary systolic array with triangular input skew
// and output deskew so every column sum emerges on the same cycle.
module sysa_array
  import sysa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WSTRIDE*N-1:0] w,
  input  logic [N*DW-1:0]      in,
  output logic [N*OW-1:0]      out
);

  // a_l[r][c] feeds PE(r,c); p_l[r][c] is the psum entering row r.
  logic [DW-1:0] a_l [N][N+1];
  logic [OW-1:0] p_l [N+1][N];

  for (genvar r = 0; r < N; r++) begin : g_row
    if (r == 0) begin : g_noskew
      assign a_l[0][0] = in[DW-1:0];
    end else begin : g_skew
      logic [DW-1:0] sk_q [r];
      logic [DW-1:0] sk_d [r];

      always_comb begin
        for (int i = 0; i < r; i++) sk_d[i] = sk_q[i];
        if (en) begin
          sk_d[0] = in[DW*r +: DW];
          for (int i = 1; i < r; i++) sk_d[i] = sk_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else begin
          sk_q <= sk_d;
        end
      end

      assign a_l[r][0] = sk_q[r-1];
    end

    for (genvar c = 0; c < N; c++) begin : g_col
      sysa_pe u_pe (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .w_in     (w[WSTRIDE*r + DW*c +: DW]),
        .a_in     (a_l[r][c]),
        .psum_in  (p_l[r][c]),
        .a_out    (a_l[r][c+1]),
        .psum_out (p_l[r+1][c])
      );
    end
  end

  for (genvar c = 0; c < N; c++) begin : g_out
    assign p_l[0][c] = '0;

    if (c == N - 1) begin : g_direct
      assign out[OW*c +: OW] = p_l[N][c];
    end else begin : g_deskew
      localparam int D = N - 1 - c;
      logic [OW-1:0] dk_q [D];
      logic [OW-1:0] dk_d [D];

      always_comb begin
        for (int i = 0; i < D; i++) dk_d[i] = dk_q[i];
        if (en) begin
          dk_d[0] = p_l[N][c];
          for (int i = 1; i < D; i++) dk_d[i] = dk_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) dk_q[i] <= '0;
        end else begin
          dk_q <= dk_d;
        end
      end

      assign out[OW*c +: OW] = dk_q[D-1];
    end
  end

endmodule

// File: tb/tb_sysa_array.sv
// Bench for sysa_array: directed literal cases plus randomized streams
// checked every cycle against a dot-product reference model.
module tb_sysa_array;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [95:0] w   = '0;
  logic [23:0] in  = '0;
  logic [47:0] out;

  always #5 clk = ~clk;

  sysa_array dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .w   (w),
    .in  (in),
    .out (out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [47:0] act, logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: weights as a matrix, vector history, output hold.
  int          wm [3][3];
  logic [23:0] hist [$];
  logic [47:0] exp_out = '0;
  bit          live = 1'b0;

  function automatic logic [47:0] dot(logic [23:0] x);
    logic [47:0] res;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      int s;
      s = 0;
      for (int r = 0; r < 3; r++) s += int'(x[8*r +: 8]) * wm[r][c];
      res[16*c +: 16] = 16'(s);
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) wm[r][c] = 0;
      exp_out = '0;
      live    = 1'b1;
    end else if (!en) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) wm[r][c] = int'(w[32*r + 8*c +: 8]);
    end else begin
      hist.push_back(in);
      if (hist.size() > 4) begin
        exp_out = dot(hist[0]);
        void'(hist.pop_front());
      end
    end
    #1;
    if (live) chk("model_out", out, exp_out);
  end

  function automatic logic [95:0] rw();
    return {$urandom, $urandom, $urandom};
  endfunction

  function automatic logic [23:0] rin();
    return 24'($urandom);
  endfunction

  task automatic step(bit r, bit e, logic [95:0] wv, logic [23:0] iv);
    @(negedge clk);
    rst = r;
    en  = e;
    w   = wv;
    in  = iv;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, rw(), 24'h0);
  endtask

  task automatic flush_load(logic [95:0] wv);
    step(1'b1, 1'b0, rw(), rin());
    step(1'b0, 1'b0, wv, rin());
  endtask

  localparam logic [95:0] WI = {32'h0001_0000, 32'h0000_0100, 32'h0000_0001};
  localparam logic [95:0] W1 = {3{32'h0001_0101}};
  localparam logic [95:0] WF = {3{32'h00FF_FFFF}};

  initial begin
    logic [95:0] wp;
    bit          e;

    step(1'b1, 1'($urandom), rw(), rin());
    step(1'b1, 1'($urandom), rw(), rin());
    chk("reset_out", out, 48'h0);
    idle(3);
    chk("idle_zero", out, 48'h0);

    flush_load(WI);
    step(1'b0, 1'b1, rw(), 24'h03_02_01);
    idle(3);
    chk("ident_early", out, 48'h0);
    idle(1);
    chk("identity", out, 48'h0003_0002_0001);

    flush_load(W1);
    step(1'b0, 1'b1, rw(), 24'h03_02_01);
    idle(4);
    chk("ones", out, 48'h0006_0006_0006);

    flush_load(W1);
    step(1'b0, 1'b1, rw(), 24'h01_01_01);
    step(1'b0, 1'b1, rw(), 24'h02_02_02);
    step(1'b0, 1'b1, rw(), 24'h03_03_03);
    idle(2);
    chk("stream_3", out, 48'h0003_0003_0003);
    idle(1);
    chk("stream_6", out, 48'h0006_0006_0006);
    idle(1);
    chk("stream_9", out, 48'h0009_0009_0009);
    idle(1);
    chk("stream_end", out, 48'h0);

    flush_load(WF);
    step(1'b0, 1'b1, rw(), 24'hFF_FF_FF);
    idle(4);
    chk("overflow", out, 48'hFA03_FA03_FA03);

    flush_load(W1);
    step(1'b0, 1'b1, rw(), 24'h01_01_01);
    step(1'b0, 1'b1, rw(), 24'h02_02_02);
    idle(3);
    chk("pre_stall", out, 48'h0003_0003_0003);
    step(1'b0, 1'b0, W1, rin());
    chk("stall_1", out, 48'h0003_0003_0003);
    step(1'b0, 1'b0, W1, rin());
    chk("stall_2", out, 48'h0003_0003_0003);
    idle(1);
    chk("post_stall", out, 48'h0006_0006_0006);
    idle(1);
    chk("post_stall_end", out, 48'h0);

    flush_load(W1);
    step(1'b0, 1'b1, rw(), 24'h05_05_05);
    step(1'b0, 1'b1, rw(), 24'h07_07_07);
    idle(1);
    step(1'b1, 1'b1, rw(), rin());
    chk("midreset", out, 48'h0);
    idle(4);
    chk("midreset_drain", out, 48'h0);

    for (int ph = 0; ph < 8; ph++) begin
      wp = rw();
      flush_load(wp);
      for (int i = 0; i < 40; i++) begin
        e = ($urandom % 5) != 0;
        step(1'b0, e, e ? rw() : wp, rin());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
